btn_debounce_oneshot: RTL and testbench
=======================================

Name: btn_debounce_oneshot

Overview:
- Conditions the raw Basys3 push-buttons before they reach the OTTER wrapper's buttons bus and interrupt input.
- Per button, the block synchronises, debounces and edge-detects the input.
- Outputs per button: a clean level, one-cycle press and release strobes, and a masked one-cycle interrupt pulse for the MCU `intr` input.
- Runs on the divided 50 MHz system clock that the wrapper uses for its IO registers.

Parameters:
- N_BTN, 5: number of buttons handled.
- DB_CYCLES, 250000: number of cycles the synchronised input must be stable before a level change is accepted (5 ms at 50 MHz). Legal range is 2 or more.
- INTR_MASK, 5'b10000: bitmask of N_BTN bits selecting which press strobes drive `intr_pulse`.
- REPEAT_CYCLES, 25000000: autorepeat period. Used only with BTN_AUTOREPEAT_EN.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- btn_raw  in  N_BTN  raw, asynchronous button pins.
- btn_db  out  N_BTN  debounced button level.
- btn_press  out  N_BTN  one-cycle strobe per accepted press.
- btn_release  out  N_BTN  one-cycle strobe per accepted release.
- intr_pulse  out  1  one-cycle pulse equal to the registered OR of (btn_press & INTR_MASK).

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- While rst_n=0, all sync flops, counters and FSMs clear at once. All outputs are 0 and every FSM is in IDLE.
- Synchroniser: two flops per bit, sync2 = btn_raw delayed by 2 edges. Only sync2 is used downstream.
- Each button has an independent FSM plus a counter of width $clog2(DB_CYCLES).
- IDLE (btn_db=0):
  - sync2=1 -> PRESS_WAIT, cnt=0.
- PRESS_WAIT (btn_db=0):
  - sync2=0 -> IDLE.
  - Else if cnt==DB_CYCLES-1 -> HELD, btn_db<=1, btn_press<=1 for one cycle.
  - Else cnt++.
- HELD (btn_db=1):
  - sync2=0 -> RELEASE_WAIT, cnt=0.
- RELEASE_WAIT (btn_db=1):
  - sync2=1 -> HELD, with no strobe.
  - Else if cnt==DB_CYCLES-1 -> IDLE, btn_db<=0, btn_release<=1 for one cycle.
  - Else cnt++.
- Latency: btn_raw rising before edge 0 and held stable gives btn_press=1 in the cycle after edge DB_CYCLES+2. Release is symmetric.
- Bounce: any sync2 glitch shorter than DB_CYCLES cycles produces no btn_db change and no strobe. The counter restarts on every new qualifying edge.
- Strobes are registered outputs and are never asserted for 2 consecutive cycles in non-repeat mode.
- Simultaneous presses: buttons are fully independent. intr_pulse is asserted once (one cycle) even if several masked buttons strobe in the same cycle. Latency is btn_press + 1 cycle.
- Button already held when rst_n deasserts: it is treated as a fresh press, so btn_press fires DB_CYCLES+2 edges after reset release.
- Reset asserted mid-debounce: the FSM aborts immediately with no strobe.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Each HELD button has a repeat counter that clears on entry to HELD, including re-entry from RELEASE_WAIT.
  - Every REPEAT_CYCLES cycles spent continuously in HELD, a further one-cycle btn_press is emitted, and also intr_pulse if the button is masked.
  - RELEASE_WAIT freezes the repeat counter and emits no repeat strobes.
- Undefined: no repeat logic is built, and exactly one btn_press is issued per accepted press.

Test Plan:
- DB_CYCLES=4, reset, then btn_raw[0]=1 held stable from edge 0 -> btn_press[0]=1 for exactly one cycle after edge 6; btn_db[0]=1 from then on; no release.
- DB_CYCLES=4, btn_raw[1] toggles 1/0 every 2 cycles for 20 cycles then settles at 1 -> no strobes during bouncing; one btn_press[1] 6 edges after it settles.
- DB_CYCLES=4, btn_raw[4] and btn_raw[2] rise on the same cycle, INTR_MASK=5'b10100 -> btn_press[4] and btn_press[2] fire in the same cycle; intr_pulse=1 for exactly one cycle, the next cycle.
- DB_CYCLES=4, press btn_raw[3] and drop rst_n at edge 4 -> all outputs 0 immediately. With btn still 1, release rst_n -> btn_press[3] fires 6 edges after release.
- DB_CYCLES=4, held button, then a 2-cycle low glitch -> no btn_release and btn_db stays 1. A sustained low produces btn_release one cycle long after 6 edges.
- BTN_AUTOREPEAT_EN, DB_CYCLES=4, REPEAT_CYCLES=10, btn_raw[0] held for 40 cycles -> btn_press[0] at debounce, then every 10 cycles (3 repeats); single btn_release after letting go.

Source files
------------

// File: rtl/btn_debounce_oneshot.sv
// Push-button conditioner: 2-flop synchroniser, per-button debounce FSM, press/release strobes, masked interrupt pulse.
// Latency: raw edge -> btn_press/btn_release after DB_CYCLES+2 clocks; intr_pulse follows btn_press by one clock.
// Backpressure: none; strobes are single-cycle and must be consumed in the cycle they appear.
//
// Ports:
//   clk          system clock (rising edge)
//   rst_n        asynchronous active-low reset
//   btn_raw      raw asynchronous button pins        [N_BTN]
//   btn_db       debounced button level               [N_BTN]
//   btn_press    one-cycle strobe per accepted press  [N_BTN]
//   btn_release  one-cycle strobe per accepted release[N_BTN]
//   intr_pulse   one-cycle pulse = registered |(btn_press & INTR_MASK)
//
// Optional build macro:
//   BTN_AUTOREPEAT_EN  a button held in HELD re-issues btn_press every
//                      REPEAT_CYCLES cycles. Undefined: one press per hold.

module btn_debounce_oneshot #(
  parameter int              N_BTN         = 5,
  parameter int              DB_CYCLES     = 250000,
  parameter logic [N_BTN-1:0] INTR_MASK    = 5'b10000,
  parameter int              REPEAT_CYCLES = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             intr_pulse
);

  // DB_CYCLES >= 2, so the counter is at least one bit wide and only ever
  // needs to reach DB_CYCLES-1.
  localparam int                CNT_W    = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; only sync2 feeds the FSMs.
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-button debounce state
  // ---------------------------------------------------------------------------
  db_state_e        state_q [N_BTN];
  db_state_e        state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];

  logic [N_BTN-1:0] db_q,      db_d;
  logic [N_BTN-1:0] press_q,   press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic             intr_q,    intr_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int                RPT_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0]  RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt_q [N_BTN];
  logic [RPT_W-1:0] rpt_d [N_BTN];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
`ifdef BTN_AUTOREPEAT_EN
        rpt_q[i]   <= '0;
`endif
      end
      db_q      <= '0;
      press_q   <= '0;
      release_q <= '0;
      intr_q    <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
`ifdef BTN_AUTOREPEAT_EN
        rpt_q[i]   <= rpt_d[i];
`endif
      end
      db_q      <= db_d;
      press_q   <= press_d;
      release_q <= release_d;
      intr_q    <= intr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Each button is independent; the only cross-button
  // coupling is the OR-reduction into intr_pulse.
  // ---------------------------------------------------------------------------
  always_comb begin
    db_d      = db_q;
    press_d   = '0;
    release_d = '0;
    // Registered version of the press strobe, so several masked buttons
    // striking together still give a single one-cycle pulse.
    intr_d    = |(press_q & INTR_MASK);

    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef BTN_AUTOREPEAT_EN
      rpt_d[i]   = rpt_q[i];
`endif

      case (state_q[i])
        IDLE: begin
          if (sync2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = '0;
          end
        end

        PRESS_WAIT: begin
          if (!sync2_q[i]) begin
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = HELD;
            db_d[i]    = 1'b1;
            press_d[i] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rpt_d[i]   = '0;
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end

        HELD: begin
          if (!sync2_q[i]) begin
            // Leaving HELD takes priority over a coincident repeat tick.
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (rpt_q[i] == RPT_LAST) begin
            press_d[i] = 1'b1;
            rpt_d[i]   = '0;
          end else begin
            rpt_d[i] = rpt_q[i] + RPT_W'(1);
          end
`endif
        end

        RELEASE_WAIT: begin
          // Repeat counter is left untouched here; it restarts on HELD entry.
          if (sync2_q[i]) begin
            state_d[i] = HELD;
`ifdef BTN_AUTOREPEAT_EN
            rpt_d[i]   = '0;
`endif
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]   = IDLE;
            db_d[i]      = 1'b0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end

        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
          db_d[i]    = 1'b0;
        end
      endcase
    end
  end

  assign btn_db      = db_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign intr_pulse  = intr_q;

endmodule

// File: tb/tb_btn_debounce_oneshot.sv
// Testbench for btn_debounce_oneshot with DB_CYCLES=4, REPEAT_CYCLES=10, INTR_MASK=5'b10100.
// Expected strobe events are queued with their edge index; each cycle pops and compares.
// Edge numbering restarts at 0 in every scenario: the first rising edge after the stimulus is set.

module tb_btn_debounce_oneshot;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] btn_raw = 5'b0;
  logic [4:0] btn_db;
  logic [4:0] btn_press;
  logic [4:0] btn_release;
  logic       intr_pulse;

  btn_debounce_oneshot #(
    .N_BTN(5),
    .DB_CYCLES(4),
    .INTR_MASK(5'b10100),
    .REPEAT_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_db(btn_db),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .intr_pulse(intr_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         e;
    logic [4:0] press;
    logic [4:0] rel;
    logic       intr;
  } exp_t;

  exp_t       sbq[$];
  logic [4:0] db_exp = 5'b0;
  int         n_vec  = 0;
  int         n_miss = 0;

  function automatic exp_t mk(input int e, input logic [4:0] p, input logic [4:0] r, input logic i);
    exp_t x;
    x.e = e; x.press = p; x.rel = r; x.intr = i;
    return x;
  endfunction

  // Scoreboard pop: returns the strobes expected at edge e and tracks the level.
  task automatic pop_expect(input int e, output logic [4:0] ep, output logic [4:0] er, output logic ei);
    exp_t x;
    ep = '0; er = '0; ei = 1'b0;
    if (sbq.size() > 0 && sbq[0].e == e) begin
      x  = sbq.pop_front();
      ep = x.press; er = x.rel; ei = x.intr;
    end
    db_exp = (db_exp | ep) & ~er;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; btn_raw = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    db_exp = '0;
    sbq.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1 btn_raw = 5'h1f;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({btn_db, btn_press, btn_release, intr_pulse} !== 16'h0) begin
        n_miss++;
        $display("FAIL reset c=%0d got db=%b p=%b r=%b i=%b want all 0", c, btn_db, btn_press, btn_release, intr_pulse);
      end
    end
    do_reset();
  endtask

  task automatic test_single_press();
    logic [4:0] ep, er; logic ei;
    do_reset();
    sbq.push_back(mk(6, 5'b00001, 5'b0, 1'b0));
    btn_raw = 5'b00001;
    for (int e = 0; e <= 14; e++) begin
      @(posedge clk); #1;
      pop_expect(e, ep, er, ei);
      n_vec++;
      if ({btn_press, btn_release, intr_pulse} !== {ep, er, ei}) begin
        n_miss++;
        $display("FAIL single_strobe e=%0d got p=%b r=%b i=%b want p=%b r=%b i=%b", e, btn_press, btn_release, intr_pulse, ep, er, ei);
      end
      n_vec++;
      if (btn_db !== db_exp) begin
        n_miss++;
        $display("FAIL single_level e=%0d got db=%b want %b", e, btn_db, db_exp);
      end
    end
    n_vec++;
    if (sbq.size() != 0) begin n_miss++; $display("FAIL single_left got %0d pending want 0", sbq.size()); end
  endtask

  task automatic test_bounce();
    logic [4:0] ep, er; logic ei;
    do_reset();
    sbq.push_back(mk(26, 5'b00010, 5'b0, 1'b0));
    btn_raw = 5'b00010;
    for (int e = 0; e <= 30; e++) begin
      @(posedge clk); #1;
      pop_expect(e, ep, er, ei);
      n_vec++;
      if ({btn_press, btn_release, intr_pulse} !== {ep, er, ei}) begin
        n_miss++;
        $display("FAIL bounce_strobe e=%0d got p=%b r=%b i=%b want p=%b r=%b i=%b", e, btn_press, btn_release, intr_pulse, ep, er, ei);
      end
      n_vec++;
      if (btn_db !== db_exp) begin
        n_miss++;
        $display("FAIL bounce_level e=%0d got db=%b want %b", e, btn_db, db_exp);
      end
      btn_raw = ((e + 1) >= 20 || (((e + 1) / 2) % 2) == 0) ? 5'b00010 : 5'b00000;
    end
    n_vec++;
    if (sbq.size() != 0) begin n_miss++; $display("FAIL bounce_left got %0d pending want 0", sbq.size()); end
  endtask

  task automatic test_simultaneous();
    logic [4:0] ep, er; logic ei;
    do_reset();
    sbq.push_back(mk(6, 5'b10100, 5'b0, 1'b0));
    sbq.push_back(mk(7, 5'b00000, 5'b0, 1'b1));
    btn_raw = 5'b10100;
    for (int e = 0; e <= 10; e++) begin
      @(posedge clk); #1;
      pop_expect(e, ep, er, ei);
      n_vec++;
      if ({btn_press, btn_release, intr_pulse} !== {ep, er, ei}) begin
        n_miss++;
        $display("FAIL simul_strobe e=%0d got p=%b r=%b i=%b want p=%b r=%b i=%b", e, btn_press, btn_release, intr_pulse, ep, er, ei);
      end
      n_vec++;
      if (btn_db !== db_exp) begin
        n_miss++;
        $display("FAIL simul_level e=%0d got db=%b want %b", e, btn_db, db_exp);
      end
    end
    n_vec++;
    if (sbq.size() != 0) begin n_miss++; $display("FAIL simul_left got %0d pending want 0", sbq.size()); end
  endtask

  task automatic test_reset_mid();
    logic [4:0] ep, er; logic ei;
    do_reset();
    // Button 0 settles to held; button 3 is mid-debounce when reset drops.
    sbq.push_back(mk(6, 5'b00001, 5'b0, 1'b0));
    btn_raw = 5'b00001;
    for (int e = 0; e <= 8; e++) begin
      @(posedge clk); #1;
      pop_expect(e, ep, er, ei);
      n_vec++;
      if ({btn_press, btn_release, intr_pulse} !== {ep, er, ei}) begin
        n_miss++;
        $display("FAIL rstmid_strobe e=%0d got p=%b r=%b i=%b want p=%b r=%b i=%b", e, btn_press, btn_release, intr_pulse, ep, er, ei);
      end
      n_vec++;
      if (btn_db !== db_exp) begin
        n_miss++;
        $display("FAIL rstmid_level e=%0d got db=%b want %b", e, btn_db, db_exp);
      end
      btn_raw = (e + 1 >= 3) ? 5'b01001 : 5'b00001;
    end
    rst_n = 1'b0;
    db_exp = '0;
    #1;
    n_vec++;
    if ({btn_db, btn_press, btn_release, intr_pulse} !== 16'h0) begin
      n_miss++;
      $display("FAIL rstmid_async got db=%b p=%b r=%b i=%b want all 0", btn_db, btn_press, btn_release, intr_pulse);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({btn_db, btn_press, btn_release, intr_pulse} !== 16'h0) begin
        n_miss++;
        $display("FAIL rstmid_hold c=%0d got db=%b p=%b r=%b i=%b want all 0", c, btn_db, btn_press, btn_release, intr_pulse);
      end
    end
    rst_n = 1'b1;
    sbq.push_back(mk(6, 5'b01001, 5'b0, 1'b0));
    for (int e = 0; e <= 10; e++) begin
      @(posedge clk); #1;
      pop_expect(e, ep, er, ei);
      n_vec++;
      if ({btn_press, btn_release, intr_pulse} !== {ep, er, ei}) begin
        n_miss++;
        $display("FAIL rstrel_strobe e=%0d got p=%b r=%b i=%b want p=%b r=%b i=%b", e, btn_press, btn_release, intr_pulse, ep, er, ei);
      end
      n_vec++;
      if (btn_db !== db_exp) begin
        n_miss++;
        $display("FAIL rstrel_level e=%0d got db=%b want %b", e, btn_db, db_exp);
      end
    end
    n_vec++;
    if (sbq.size() != 0) begin n_miss++; $display("FAIL rstmid_left got %0d pending want 0", sbq.size()); end
  endtask

  task automatic test_glitch_release();
    logic [4:0] ep, er; logic ei;
    do_reset();
    sbq.push_back(mk(6,  5'b00001, 5'b0,     1'b0));
    sbq.push_back(mk(26, 5'b00000, 5'b00001, 1'b0));
    btn_raw = 5'b00001;
    for (int e = 0; e <= 30; e++) begin
      @(posedge clk); #1;
      pop_expect(e, ep, er, ei);
      n_vec++;
      if ({btn_press, btn_release, intr_pulse} !== {ep, er, ei}) begin
        n_miss++;
        $display("FAIL glitch_strobe e=%0d got p=%b r=%b i=%b want p=%b r=%b i=%b", e, btn_press, btn_release, intr_pulse, ep, er, ei);
      end
      n_vec++;
      if (btn_db !== db_exp) begin
        n_miss++;
        $display("FAIL glitch_level e=%0d got db=%b want %b", e, btn_db, db_exp);
      end
      btn_raw = ((e + 1) < 10 || ((e + 1) >= 12 && (e + 1) < 20)) ? 5'b00001 : 5'b00000;
    end
    n_vec++;
    if (sbq.size() != 0) begin n_miss++; $display("FAIL glitch_left got %0d pending want 0", sbq.size()); end
  endtask

  task automatic test_hold_repeat();
    logic [4:0] ep, er; logic ei;
    do_reset();
    sbq.push_back(mk(6, 5'b00001, 5'b0, 1'b0));
`ifdef BTN_AUTOREPEAT_EN
    sbq.push_back(mk(16, 5'b00001, 5'b0, 1'b0));
    sbq.push_back(mk(26, 5'b00001, 5'b0, 1'b0));
    sbq.push_back(mk(36, 5'b00001, 5'b0, 1'b0));
`endif
    sbq.push_back(mk(46, 5'b00000, 5'b00001, 1'b0));
    btn_raw = 5'b00001;
    for (int e = 0; e <= 50; e++) begin
      @(posedge clk); #1;
      pop_expect(e, ep, er, ei);
      n_vec++;
      if ({btn_press, btn_release, intr_pulse} !== {ep, er, ei}) begin
        n_miss++;
        $display("FAIL hold_strobe e=%0d got p=%b r=%b i=%b want p=%b r=%b i=%b", e, btn_press, btn_release, intr_pulse, ep, er, ei);
      end
      n_vec++;
      if (btn_db !== db_exp) begin
        n_miss++;
        $display("FAIL hold_level e=%0d got db=%b want %b", e, btn_db, db_exp);
      end
      btn_raw = ((e + 1) < 40) ? 5'b00001 : 5'b00000;
    end
    n_vec++;
    if (sbq.size() != 0) begin n_miss++; $display("FAIL hold_left got %0d pending want 0", sbq.size()); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_glitch_release();
    test_hold_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
